// File: rtl/display_msg_ctrl.sv
// display_msg_ctrl
// Eight-digit character display controller with a 16-entry message buffer.
// Characters are appended one at a time, the last one can be deleted and the
// buffer can be cleared. The window shows the tail of the message while
// editing. When auto-scroll is enabled and the message is longer than eight
// characters, the window walks from the head of the message to its end. It
// then pauses at the end and restarts from the head.
//
// Ports
//   clkout    in   1  clock, all state changes on the rising edge
//   rst       in   1  asynchronous active-high reset
//   wr_valid  in   1  character write request
//   wr_char   in   6  character code (0-9 digits, 10-35 letters A-Z)
//   wr_ready  out  1  write is accepted this cycle when wr_valid && wr_ready
//   bksp      in   1  delete the last character (level, sampled every cycle)
//   clr       in   1  empty the buffer
//   scroll_en in   1  enable auto-scroll for messages longer than eight
//   r0..r7    out  6  displayed character codes, r0 is the leftmost digit
//   state     out  4  number of lit digits, 0..8
//   wr_err    out  1  one-cycle pulse for a rejected write
module display_msg_ctrl #(
  parameter int STEP = 250,
  parameter int HOLD = 500
) (
  input  logic       clkout,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [5:0] wr_char,
  output logic       wr_ready,
  input  logic       bksp,
  input  logic       clr,
  input  logic       scroll_en,
  output logic [5:0] r0,
  output logic [5:0] r1,
  output logic [5:0] r2,
  output logic [5:0] r3,
  output logic [5:0] r4,
  output logic [5:0] r5,
  output logic [5:0] r6,
  output logic [5:0] r7,
  output logic [3:0] state,
  output logic       wr_err
);

  localparam logic [1:0] ST_EDIT   = 2'd0;
  localparam logic [1:0] ST_SCROLL = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam int STEP_W = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);

  logic [1:0]        fsm_r;
  logic [4:0]        len_r;
  logic [3:0]        offset_r;
  logic [STEP_W-1:0] step_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [5:0]        char_buf_r [16];

  logic [4:0] len_dec_s;
  logic       wr_accept_s;
  logic       wr_store_s;
  logic       wr_reject_s;
  logic [4:0] base_s;
  logic [3:0] lit_s;
  logic [5:0] win_s [8];

  // Writes are only taken while editing, with room left and no clr/bksp pending.
  assign wr_ready = (fsm_r == ST_EDIT) && (len_r < 5'd16) && !clr && !bksp;

  // Write qualification and the decremented length used by backspace.
  always_comb begin
    len_dec_s   = len_r - 5'd1;
    wr_accept_s = wr_valid && wr_ready;
    wr_store_s  = wr_accept_s && (wr_char <= 6'd35);
    // A write is rejected for a bad code or because the buffer is full. It is
    // dropped silently when clr or bksp wins the cycle.
    wr_reject_s = (fsm_r == ST_EDIT) && !clr && !bksp && wr_valid &&
                  ((len_r == 5'd16) || (wr_char > 6'd35));
  end

  // Display window: tail view while editing, scroll offset otherwise.
  always_comb begin
    base_s = 5'd0;
    lit_s  = 4'd0;
    case (fsm_r)
      ST_EDIT: begin
        if (len_r > 5'd8) begin
          base_s = len_r - 5'd8;
        end else begin
          base_s = 5'd0;
        end
      end
      ST_SCROLL, ST_HOLD: base_s = {1'b0, offset_r};
      default:            base_s = 5'd0;
    endcase
    if (len_r > 5'd8) begin
      lit_s = 4'd8;
    end else begin
      lit_s = len_r[3:0];
    end
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < lit_s) begin
        win_s[i] = char_buf_r[4'(base_s + 5'(i))];
      end else begin
        win_s[i] = 6'd0;
      end
    end
  end

  // Character storage: an accepted legal write lands at the current tail.
  always_ff @(posedge clkout or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        char_buf_r[i] <= 6'd0;
      end
    end else if (wr_store_s) begin
      char_buf_r[len_r[3:0]] <= wr_char;
    end
  end

  // Length, scroll FSM, offset and step/hold counters.
  always_ff @(posedge clkout or posedge rst) begin
    if (rst) begin
      fsm_r      <= ST_EDIT;
      len_r      <= 5'd0;
      offset_r   <= 4'd0;
      step_cnt_r <= {STEP_W{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else if (clr) begin
      fsm_r      <= ST_EDIT;
      len_r      <= 5'd0;
      offset_r   <= 4'd0;
      step_cnt_r <= {STEP_W{1'b0}};
      hold_cnt_r <= {HOLD_W{1'b0}};
    end else if (bksp) begin
      // Scrolling is frozen for the backspace cycle. Only the window is
      // pulled back so that it never runs past the shortened message.
      if (len_r != 5'd0) begin
        len_r <= len_dec_s;
        if (fsm_r != ST_EDIT) begin
          if (len_dec_s <= 5'd8) begin
            fsm_r    <= ST_EDIT;
            offset_r <= 4'd0;
          end else if ({1'b0, offset_r} > (len_dec_s - 5'd8)) begin
            offset_r <= 4'(len_dec_s - 5'd8);
          end
        end
      end
    end else begin
      case (fsm_r)
        ST_EDIT: begin
          if (wr_store_s) begin
            len_r <= len_r + 5'd1;
          end
          // The decision uses the length before this cycle's write.
          if (scroll_en && (len_r > 5'd8)) begin
            fsm_r      <= ST_SCROLL;
            offset_r   <= 4'd0;
            step_cnt_r <= {STEP_W{1'b0}};
            hold_cnt_r <= {HOLD_W{1'b0}};
          end
        end
        ST_SCROLL: begin
          if (!scroll_en) begin
            fsm_r    <= ST_EDIT;
            offset_r <= 4'd0;
          end else if (step_cnt_r == STEP_LAST) begin
            step_cnt_r <= {STEP_W{1'b0}};
            if ({1'b0, offset_r} == (len_r - 5'd8)) begin
              fsm_r      <= ST_HOLD;
              hold_cnt_r <= {HOLD_W{1'b0}};
            end else begin
              offset_r <= offset_r + 4'd1;
            end
          end else begin
            step_cnt_r <= step_cnt_r + {{(STEP_W-1){1'b0}}, 1'b1};
          end
        end
        ST_HOLD: begin
          if (!scroll_en) begin
            fsm_r    <= ST_EDIT;
            offset_r <= 4'd0;
          end else if (hold_cnt_r == HOLD_LAST) begin
            fsm_r      <= ST_SCROLL;
            offset_r   <= 4'd0;
            step_cnt_r <= {STEP_W{1'b0}};
          end else begin
            hold_cnt_r <= hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          fsm_r    <= ST_EDIT;
          offset_r <= 4'd0;
        end
      endcase
    end
  end

  // Registered display outputs and the write-error pulse.
  always_ff @(posedge clkout or posedge rst) begin
    if (rst) begin
      r0     <= 6'd0;
      r1     <= 6'd0;
      r2     <= 6'd0;
      r3     <= 6'd0;
      r4     <= 6'd0;
      r5     <= 6'd0;
      r6     <= 6'd0;
      r7     <= 6'd0;
      state  <= 4'd0;
      wr_err <= 1'b0;
    end else begin
      r0     <= win_s[0];
      r1     <= win_s[1];
      r2     <= win_s[2];
      r3     <= win_s[3];
      r4     <= win_s[4];
      r5     <= win_s[5];
      r6     <= win_s[6];
      r7     <= win_s[7];
      state  <= lit_s;
      wr_err <= wr_reject_s;
    end
  end

endmodule

// File: tb/tb_display_msg_ctrl.sv
// Testbench for display_msg_ctrl. It runs directed scenarios with
// hand-computed values and then a randomized run. Both are checked every
// cycle against a message/window model built from the behavioural rules.
module tb_display_msg_ctrl;
  localparam int STEP = 2;
  localparam int HOLD = 3;

  logic       clkout = 1'b0;
  logic       rst, wr_valid, bksp, clr, scroll_en, wr_ready, wr_err;
  logic [5:0] wr_char;
  logic [5:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [3:0] state;
  logic [5:0] dr [8];

  int total = 0;
  int bad   = 0;

  // reference model: message contents, length, mode (0 edit, 1 scroll, 2 pause)
  int mbuf [16];
  int mlen, mmode, moff, mstep, mhold;
  int exp_r [8];
  int exp_state, exp_err;

  display_msg_ctrl #(.STEP(STEP), .HOLD(HOLD)) dut (
    .clkout(clkout), .rst(rst), .wr_valid(wr_valid), .wr_char(wr_char),
    .wr_ready(wr_ready), .bksp(bksp), .clr(clr), .scroll_en(scroll_en),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .state(state), .wr_err(wr_err)
  );

  always #5 clkout = ~clkout;

  assign dr[0] = r0; assign dr[1] = r1; assign dr[2] = r2; assign dr[3] = r3;
  assign dr[4] = r4; assign dr[5] = r5; assign dr[6] = r6; assign dr[7] = r7;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mbuf[i] = 0;
    mlen = 0; mmode = 0; moff = 0; mstep = 0; mhold = 0;
    for (int i = 0; i < 8; i++) exp_r[i] = 0;
    exp_state = 0; exp_err = 0;
  endtask

  function automatic int model_ready();
    return (mmode == 0 && mlen < 16 && !clr && !bksp) ? 1 : 0;
  endfunction

  // One clock edge of the model. Outputs come from the state before the edge.
  task automatic model_edge();
    int base, n, olen;
    base = (mmode == 0) ? ((mlen > 8) ? mlen - 8 : 0) : moff;
    n = (mlen > 8) ? 8 : mlen;
    for (int i = 0; i < 8; i++) begin
      if (i < n) exp_r[i] = mbuf[base + i];
      else       exp_r[i] = 0;
    end
    exp_state = n;
    exp_err = (mmode == 0 && !clr && !bksp && wr_valid &&
               (mlen == 16 || wr_char > 35)) ? 1 : 0;
    if (clr) begin
      mlen = 0; moff = 0; mmode = 0;
    end else if (bksp) begin
      if (mlen > 0) begin
        mlen--;
        if (mmode != 0) begin
          if (mlen <= 8) begin mmode = 0; moff = 0; end
          else if (moff > mlen - 8) moff = mlen - 8;
        end
      end
    end else if (mmode == 0) begin
      olen = mlen;
      if (wr_valid && mlen < 16 && wr_char <= 35) begin
        mbuf[mlen] = int'(wr_char);
        mlen++;
      end
      if (scroll_en && olen > 8) begin mmode = 1; moff = 0; mstep = 0; mhold = 0; end
    end else if (!scroll_en) begin
      mmode = 0; moff = 0;
    end else if (mmode == 1) begin
      if (mstep == STEP - 1) begin
        mstep = 0;
        if (moff == mlen - 8) begin mmode = 2; mhold = 0; end
        else moff++;
      end else mstep++;
    end else begin
      if (mhold == HOLD - 1) begin moff = 0; mstep = 0; mmode = 1; end
      else mhold++;
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 8; i++) chk($sformatf("r%0d", i), int'(dr[i]), exp_r[i]);
    chk("state", int'(state), exp_state);
    chk("wr_err", int'(wr_err), exp_err);
  endtask

  // Inputs are set just after a falling edge. This runs one full cycle.
  task automatic cyc();
    #1;
    chk("wr_ready", int'(wr_ready), model_ready());
    @(posedge clkout);
    model_edge();
    @(negedge clkout);
    compare();
  endtask

  task automatic set_in(input logic v, input int c, input logic b, input logic cl);
    wr_valid = v; wr_char = 6'(c); bksp = b; clr = cl;
  endtask

  task automatic wr(input int c);
    set_in(1'b1, c, 1'b0, 1'b0); cyc();
  endtask

  task automatic idle();
    set_in(1'b0, 0, 1'b0, 1'b0); cyc();
  endtask

  task automatic clear();
    set_in(1'b0, 0, 1'b0, 1'b1); cyc();
  endtask

  initial begin
    int seq [10] = '{0, 0, 1, 1, 2, 2, 2, 2, 2, 0};
    int k;
    rst = 1'b1; scroll_en = 1'b0;
    set_in(1'b0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge clkout);
    chk("reset_r0", int'(r0), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_wr_err", int'(wr_err), 0);
    model_reset();
    rst = 1'b0;

    // three writes, visible one cycle after the last
    wr(1); wr(2); wr(3); idle();
    chk("w3_state", int'(state), 3);
    chk("w3_r0", int'(r0), 1);
    chk("w3_r1", int'(r1), 2);
    chk("w3_r2", int'(r2), 3);
    chk("w3_r3", int'(r3), 0);

    // tail view and full-buffer rejection
    clear();
    for (int i = 0; i < 10; i++) wr(i);
    idle();
    chk("tail_state", int'(state), 8);
    chk("tail_r0", int'(r0), 2);
    chk("tail_r7", int'(r7), 9);
    for (int i = 10; i < 16; i++) wr(i);
    set_in(1'b1, 20, 1'b0, 1'b0);
    #1 chk("full_ready", int'(wr_ready), 0);
    cyc();
    chk("full_err", int'(wr_err), 1);
    idle();
    chk("full_err_gone", int'(wr_err), 0);
    chk("full_r7", int'(r7), 15);
    chk("full_r0", int'(r0), 8);

    // scroll sequence with STEP=2, HOLD=3
    clear();
    for (int i = 0; i < 10; i++) wr(i);
    scroll_en = 1'b1;
    idle();
    chk("scr_start_r0", int'(r0), 2);
    for (int i = 0; i < 10; i++) begin
      idle();
      chk($sformatf("scr_seq%0d", i), int'(r0), seq[i]);
    end

    // backspace during the end-of-scroll pause
    k = 0;
    while (mmode != 2 && k < 20) begin idle(); k++; end
    chk("reach_hold_r0", int'(r0), (k < 20) ? 2 : -1);
    set_in(1'b0, 0, 1'b1, 1'b0); cyc();
    set_in(1'b0, 0, 1'b1, 1'b0); cyc();
    chk("bk1_r0", int'(r0), 1);
    chk("bk1_state", int'(state), 8);
    idle();
    chk("bk2_r0", int'(r0), 0);
    chk("bk2_state", int'(state), 8);
    scroll_en = 1'b0;

    // clr > bksp > write priority, and an illegal code
    clear();
    for (int i = 0; i < 5; i++) wr(i + 20);
    idle();
    set_in(1'b1, 3, 1'b1, 1'b1); cyc();
    chk("prio_err", int'(wr_err), 0);
    idle();
    chk("prio_state", int'(state), 0);
    chk("prio_err2", int'(wr_err), 0);
    wr(36);
    chk("bad_code_err", int'(wr_err), 1);
    idle();
    chk("bad_code_state", int'(state), 0);

    // asynchronous reset while scrolling
    for (int i = 0; i < 10; i++) wr(i);
    scroll_en = 1'b1;
    idle(); idle(); idle();
    #2 rst = 1'b1;
    #1;
    chk("arst_r0", int'(r0), 0);
    chk("arst_r5", int'(r5), 0);
    chk("arst_state", int'(state), 0);
    chk("arst_ready", int'(wr_ready), 1);
    @(negedge clkout);
    model_reset();
    scroll_en = 1'b0;
    rst = 1'b0;
    wr(7); idle();
    chk("post_rst_r0", int'(r0), 7);
    chk("post_rst_state", int'(state), 1);

    // randomized run
    scroll_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      clr      = ($urandom_range(0, 49) == 0);
      bksp     = ($urandom_range(0, 9) == 0);
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_char  = 6'($urandom_range(0, 39));
      if ($urandom_range(0, 99) == 0) scroll_en = ~scroll_en;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
